// File: rtl/gen1_2_tx_framer_if.sv
// ---------------------------------------------------------------------------
// gen1_2_tx_framer_if
// Bundles the link-layer side (TLP beats, DLLP requests, ready handshakes)
// and the lane side (framed word, per-byte K flags, per-byte valid, error
// pulse) of the Gen1/2 transmit framer.
//   master : link layer / lane consumer view (drives TLP/DLLP requests)
//   slave  : framer view (drives ready, framed word and proto_err)
// Signals:
//   tlp_data[511:0]  TLP beat, byte 0 = bits[7:0]
//   tlp_valid/sop/eop, tlp_bytes[6:0] (valid bytes on eop beat), tlp_nullify
//   tlp_ready        beat accepted when tlp_valid & tlp_ready
//   dllp_data[47:0], dllp_valid, dllp_ready
//   Data_out[511:0], DK[63:0], valid[63:0], proto_err
// ---------------------------------------------------------------------------
interface gen1_2_tx_framer_if;
   logic [511:0] tlp_data;
   logic         tlp_valid;
   logic         tlp_sop;
   logic         tlp_eop;
   logic [6:0]   tlp_bytes;
   logic         tlp_nullify;
   logic         tlp_ready;
   logic [47:0]  dllp_data;
   logic         dllp_valid;
   logic         dllp_ready;
   logic [511:0] Data_out;
   logic [63:0]  DK;
   logic [63:0]  valid;
   logic         proto_err;

   modport master (
      output tlp_data, tlp_valid, tlp_sop, tlp_eop, tlp_bytes, tlp_nullify,
      output dllp_data, dllp_valid,
      input  tlp_ready, dllp_ready,
      input  Data_out, DK, valid, proto_err
   );

   modport slave (
      input  tlp_data, tlp_valid, tlp_sop, tlp_eop, tlp_bytes, tlp_nullify,
      input  dllp_data, dllp_valid,
      output tlp_ready, dllp_ready,
      output Data_out, DK, valid, proto_err
   );
endinterface

// File: rtl/gen1_2_tx_framer.sv
// ---------------------------------------------------------------------------
// gen1_2_tx_framer
// Gen1/2 transmit packet framer. Wraps TLPs as STP..END/EDB and DLLPs as
// SDP..END, pads unused bytes with PAD and emits one registered 64-byte word
// per cycle toward the scrambler / 8b10b lanes. Every packet starts at byte 0.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high reset
//   bus    : gen1_2_tx_framer_if.slave (TLP/DLLP inputs, readies, framed word)
// ---------------------------------------------------------------------------
module gen1_2_tx_framer (
   input logic               clk,
   input logic               reset,
   gen1_2_tx_framer_if.slave bus
);
   localparam int         BYTES      = 64;
   localparam int         DLLP_BYTES = 6;
   localparam logic [7:0] SYM_STP    = 8'hFB;
   localparam logic [7:0] SYM_SDP    = 8'h5C;
   localparam logic [7:0] SYM_END    = 8'hFD;
   localparam logic [7:0] SYM_EDB    = 8'hFE;
   localparam logic [7:0] SYM_PAD    = 8'hF7;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TLP_BODY = 2'd1,
      ST_TAIL     = 2'd2
   } state_t;

   state_t             r_state, w_state_next;
   logic [7:0]         r_carry, w_carry_next;
   logic               r_tail_two, w_tail_two_next;
   logic [7:0]         r_tail_sym, w_tail_sym_next;
   logic [8*BYTES-1:0] r_data, w_data_next;
   logic [BYTES-1:0]   r_dk, w_dk_next;
   logic [BYTES-1:0]   r_valid, w_valid_next;
   logic               r_proto_err, w_proto_err_next;

   logic               w_tlp_ready, w_dllp_ready, w_tlp_fire, w_dllp_fire;
   logic               w_take_beat;
   logic               w_bytes_bad;
   logic [6:0]         w_eff_bytes;
   logic [7:0]         w_end_sym;
   logic [8*BYTES-1:0] w_beat_data, w_dllp_word, w_tail_word;
   logic [BYTES-1:0]   w_beat_dk, w_dllp_dk, w_tail_dk;

   // DLLP has priority over a TLP start in IDLE; nothing is accepted in TAIL
   assign w_tlp_ready  = !reset && ((r_state == ST_IDLE && !bus.dllp_valid) ||
                                    (r_state == ST_TLP_BODY));
   assign w_dllp_ready = !reset && (r_state == ST_IDLE);
   assign w_tlp_fire   = bus.tlp_valid && w_tlp_ready;
   assign w_dllp_fire  = bus.dllp_valid && w_dllp_ready;

   // A byte count of 0 (or anything above 64) is flagged and framed as a full beat
   assign w_bytes_bad = (bus.tlp_bytes == 7'd0) || (bus.tlp_bytes > 7'd64);
   assign w_eff_bytes = w_bytes_bad ? 7'd64 : bus.tlp_bytes;
   assign w_end_sym   = bus.tlp_nullify ? SYM_EDB : SYM_END;

   // Beat word: the whole TLP stream is shifted one byte right by STP, so
   // byte 0 is either STP (first beat) or the byte carried from the last beat.
   assign w_beat_data[7:0] = (r_state == ST_IDLE) ? SYM_STP : r_carry;
   assign w_beat_dk[0]     = (r_state == ST_IDLE);

   genvar gi;
   generate
      for (gi = 1; gi < BYTES; gi++) begin : g_beat
         logic w_is_payload, w_is_end;
         assign w_is_payload = !bus.tlp_eop || (7'(gi) <= w_eff_bytes);
         assign w_is_end     = (7'(gi) == w_eff_bytes + 7'd1);
         assign w_beat_data[8*gi +: 8] = w_is_payload ? bus.tlp_data[8*(gi-1) +: 8] :
                                         (w_is_end ? w_end_sym : SYM_PAD);
         assign w_beat_dk[gi] = !w_is_payload;
      end

      for (gi = 0; gi < BYTES; gi++) begin : g_dllp
         if (gi == 0) begin : g_sdp
            assign w_dllp_word[7:0] = SYM_SDP;
            assign w_dllp_dk[0]     = 1'b1;
         end else if (gi <= DLLP_BYTES) begin : g_pay
            assign w_dllp_word[8*gi +: 8] = bus.dllp_data[8*(gi-1) +: 8];
            assign w_dllp_dk[gi]          = 1'b0;
         end else if (gi == DLLP_BYTES + 1) begin : g_end
            assign w_dllp_word[8*gi +: 8] = SYM_END;
            assign w_dllp_dk[gi]          = 1'b1;
         end else begin : g_pad
            assign w_dllp_word[8*gi +: 8] = SYM_PAD;
            assign w_dllp_dk[gi]          = 1'b1;
         end
      end

      // Tail word: either [END/EDB] or [last payload byte, END/EDB], then PAD
      for (gi = 0; gi < BYTES; gi++) begin : g_tail
         if (gi == 0) begin : g_b0
            assign w_tail_word[7:0] = r_tail_two ? r_carry : r_tail_sym;
            assign w_tail_dk[0]     = !r_tail_two;
         end else if (gi == 1) begin : g_b1
            assign w_tail_word[15:8] = r_tail_two ? r_tail_sym : SYM_PAD;
            assign w_tail_dk[1]      = 1'b1;
         end else begin : g_pad
            assign w_tail_word[8*gi +: 8] = SYM_PAD;
            assign w_tail_dk[gi]          = 1'b1;
         end
      end
   endgenerate

   always_comb begin
      w_state_next     = r_state;
      w_carry_next     = r_carry;
      w_tail_two_next  = r_tail_two;
      w_tail_sym_next  = r_tail_sym;
      w_data_next      = '0;
      w_dk_next        = '0;
      w_valid_next     = '0;
      w_proto_err_next = 1'b0;
      w_take_beat      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_dllp_fire) begin
               w_data_next  = w_dllp_word;
               w_dk_next    = w_dllp_dk;
               w_valid_next = '1;
            end else if (w_tlp_fire) begin
               if (bus.tlp_sop) w_take_beat = 1'b1;
               else             w_proto_err_next = 1'b1;   // orphan beat is dropped
            end
         end
         ST_TLP_BODY: begin
            if (w_tlp_fire) begin
               w_take_beat = 1'b1;
               if (bus.tlp_sop) w_proto_err_next = 1'b1;  // framed as continuation
            end
         end
         ST_TAIL: begin
            w_data_next  = w_tail_word;
            w_dk_next    = w_tail_dk;
            w_valid_next = '1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase

      if (w_take_beat) begin
         w_data_next  = w_beat_data;
         w_dk_next    = w_beat_dk;
         w_valid_next = '1;
         w_carry_next = bus.tlp_data[8*BYTES-1 -: 8];
         if (!bus.tlp_eop) begin
            w_state_next = ST_TLP_BODY;
         end else begin
            if (w_bytes_bad) w_proto_err_next = 1'b1;
            w_tail_sym_next = w_end_sym;
            w_tail_two_next = (w_eff_bytes == 7'd64);
            // 63 or 64 bytes leave the terminator (and maybe one payload byte) for a tail word
            w_state_next    = (w_eff_bytes <= 7'd62) ? ST_IDLE : ST_TAIL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_carry     <= '0;
         r_tail_two  <= 1'b0;
         r_tail_sym  <= '0;
         r_data      <= '0;
         r_dk        <= '0;
         r_valid     <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_carry     <= w_carry_next;
         r_tail_two  <= w_tail_two_next;
         r_tail_sym  <= w_tail_sym_next;
         r_data      <= w_data_next;
         r_dk        <= w_dk_next;
         r_valid     <= w_valid_next;
         r_proto_err <= w_proto_err_next;
      end
   end

   assign bus.tlp_ready  = w_tlp_ready;
   assign bus.dllp_ready = w_dllp_ready;
   assign bus.Data_out   = r_data;
   assign bus.DK         = r_dk;
   assign bus.valid      = r_valid;
   assign bus.proto_err  = r_proto_err;
endmodule

// File: tb/tb_gen1_2_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_gen1_2_tx_framer
// Directed stimulus for the Gen1/2 transmit framer. A byte-stream model
// (symbol queue per packet, chopped into 64-byte words) predicts every output
// word and both readies; a compare process checks the DUT on each falling
// edge, and literal expectations pin key bytes of the main scenarios.
// ---------------------------------------------------------------------------
module tb_gen1_2_tx_framer;
   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   gen1_2_tx_framer_if bus();
   gen1_2_tx_framer dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [8:0]   m_q[$];          // {K flag, byte} symbols waiting to be placed
   bit           m_in_pkt = 0;
   bit           m_tail = 0;
   bit           m_primed = 0;
   logic [511:0] e_data;
   logic [63:0]  e_dk, e_valid;
   logic         e_perr;

   function automatic bit m_tlp_ready();
      return !reset && !m_tail && (m_in_pkt || !bus.dllp_valid);
   endfunction

   function automatic bit m_dllp_ready();
      return !reset && !m_tail && !m_in_pkt;
   endfunction

   function automatic void m_emit();
      logic [8:0] s;
      e_valid = '1;
      for (int i = 0; i < 64; i++) begin
         if (m_q.size() > 0) s = m_q.pop_front();
         else                s = {1'b1, 8'hF7};
         e_data[8*i +: 8] = s[7:0];
         e_dk[i]          = s[8];
      end
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_q.delete();
         m_in_pkt = 0;
         m_tail   = 0;
         e_data   = '0;
         e_dk     = '0;
         e_valid  = '0;
         e_perr   = 0;
         m_primed = 1;
      end else begin
         bit tr, dr;
         int n;
         tr = m_tlp_ready();
         dr = m_dllp_ready();
         e_data = '0; e_dk = '0; e_valid = '0; e_perr = 0;
         if (m_tail) begin
            m_emit();
            m_tail = 0;
         end else if (bus.dllp_valid && dr) begin
            m_q.push_back({1'b1, 8'h5C});
            for (int i = 0; i < 6; i++) m_q.push_back({1'b0, bus.dllp_data[8*i +: 8]});
            m_q.push_back({1'b1, 8'hFD});
            m_emit();
         end else if (bus.tlp_valid && tr) begin
            if (!m_in_pkt && !bus.tlp_sop) begin
               e_perr = 1;
            end else begin
               if (m_in_pkt && bus.tlp_sop) e_perr = 1;
               if (!m_in_pkt) m_q.push_back({1'b1, 8'hFB});
               n = bus.tlp_eop ? int'(bus.tlp_bytes) : 64;
               if (n == 0 || n > 64) begin
                  e_perr = 1;
                  n = 64;
               end
               for (int i = 0; i < n; i++) m_q.push_back({1'b0, bus.tlp_data[8*i +: 8]});
               if (bus.tlp_eop) m_q.push_back({1'b1, bus.tlp_nullify ? 8'hFE : 8'hFD});
               m_emit();
               if (bus.tlp_eop) begin
                  m_in_pkt = 0;
                  m_tail   = (m_q.size() > 0);
               end else begin
                  m_in_pkt = 1;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_primed) begin
         check("Data_out",   bus.Data_out,           e_data);
         check("DK",         512'(bus.DK),           512'(e_dk));
         check("valid",      512'(bus.valid),        512'(e_valid));
         check("proto_err",  512'(bus.proto_err),    512'(e_perr));
         check("tlp_ready",  512'(bus.tlp_ready),    512'(m_tlp_ready()));
         check("dllp_ready", 512'(bus.dllp_ready),   512'(m_dllp_ready()));
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [511:0] pat(input logic [7:0] base);
      logic [511:0] v;
      for (int i = 0; i < 64; i++) v[8*i +: 8] = base + 8'(i);
      return v;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.tlp_valid = 0; bus.tlp_sop = 0; bus.tlp_eop = 0;
      bus.tlp_bytes = 7'd0; bus.tlp_nullify = 0; bus.tlp_data = '0;
      bus.dllp_valid = 0; bus.dllp_data = '0;
   endtask

   task automatic set_tlp(input bit sop, input bit eop, input int n, input bit nul,
                          input logic [7:0] base);
      bus.tlp_valid = 1; bus.tlp_sop = sop; bus.tlp_eop = eop;
      bus.tlp_bytes = 7'(n); bus.tlp_nullify = nul; bus.tlp_data = pat(base);
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      cycle();
      cycle();
      // 1: reset state, readies held low even with requests pending
      bus.dllp_valid = 1; bus.tlp_valid = 1; bus.tlp_sop = 1;
      #1;
      check("rst_data",       bus.Data_out,         512'h0);
      check("rst_dk",         512'(bus.DK),         512'h0);
      check("rst_valid",      512'(bus.valid),      512'h0);
      check("rst_tlp_ready",  512'(bus.tlp_ready),  512'h0);
      check("rst_dllp_ready", 512'(bus.dllp_ready), 512'h0);
      idle_inputs();
      reset = 0;
      cycle();

      // 2: DLLP
      bus.dllp_valid = 1; bus.dllp_data = 48'h060504030201;
      cycle();
      idle_inputs();
      check("dllp_bytes0_7",  512'(bus.Data_out[63:0]),   512'(64'hFD0605040302015C));
      check("dllp_pad",       512'(bus.Data_out[511:64]), 512'({56{8'hF7}}));
      check("dllp_dk",        512'(bus.DK),               512'(64'hFFFFFFFFFFFFFF81));
      check("dllp_valid",     512'(bus.valid),            512'(64'hFFFFFFFFFFFFFFFF));
      check("model_dllp_dk",  512'(e_dk),                 512'(64'hFFFFFFFFFFFFFF81));

      // 3: single-beat TLP, n=20
      set_tlp(1, 1, 20, 0, 8'h01);
      cycle();
      idle_inputs();
      check("t3_stp",   512'(bus.Data_out[7:0]),     512'(8'hFB));
      check("t3_b20",   512'(bus.Data_out[167:160]), 512'(8'h14));
      check("t3_end",   512'(bus.Data_out[175:168]), 512'(8'hFD));
      check("t3_pad",   512'(bus.Data_out[183:176]), 512'(8'hF7));
      check("t3_dk",    512'(bus.DK),                512'(64'hFFFFFFFFFFE00001));
      check("model_t3", 512'(e_dk),                  512'(64'hFFFFFFFFFFE00001));
      cycle();
      check("t3_idle",  512'(bus.valid), 512'h0);

      // 4: two beats, second n=64 nullified -> tail [last byte, EDB]
      set_tlp(1, 0, 64, 0, 8'h40);
      cycle();
      set_tlp(0, 1, 64, 1, 8'h80);
      cycle();
      check("t4_carry",    512'(bus.Data_out[7:0]), 512'(8'h7F));
      check("t4_carry_dk", 512'(bus.DK[0]),         512'(1'b0));
      set_tlp(1, 1, 5, 0, 8'h10);              // offered during the tail cycle
      #1;
      check("t4_tail_ready", 512'(bus.tlp_ready), 512'h0);
      cycle();
      check("t4_tail_b0", 512'(bus.Data_out[7:0]),  512'(8'hBF));
      check("t4_tail_b1", 512'(bus.Data_out[15:8]), 512'(8'hFE));
      check("t4_tail_dk", 512'(bus.DK[1:0]),        512'(2'b10));
      cycle();
      idle_inputs();
      check("t4_next_stp", 512'(bus.Data_out[15:0]), 512'(16'h10FB));
      cycle();

      // two beats, second n=63 -> tail [END]
      set_tlp(1, 0, 64, 0, 8'h20);
      cycle();
      set_tlp(0, 1, 63, 0, 8'h60);
      cycle();
      idle_inputs();
      check("t63_last", 512'(bus.Data_out[511:504]), 512'(8'h9E));
      cycle();
      check("t63_tail", 512'(bus.Data_out[15:0]), 512'(16'hF7FD));
      check("t63_dk",   512'(bus.DK[1:0]),        512'(2'b11));
      cycle();

      // boundary n=62: END lands on byte 63, no tail word
      set_tlp(1, 1, 62, 0, 8'h00);
      cycle();
      idle_inputs();
      check("t62_end", 512'(bus.Data_out[511:504]), 512'(8'hFD));
      cycle();
      check("t62_no_tail", 512'(bus.valid), 512'h0);

      // 5: DLLP and sop together -> DLLP first
      bus.dllp_valid = 1; bus.dllp_data = 48'hAABBCCDDEEFF;
      set_tlp(1, 1, 3, 0, 8'h30);
      #1;
      check("t5_tlp_ready",  512'(bus.tlp_ready),  512'h0);
      check("t5_dllp_ready", 512'(bus.dllp_ready), 512'h1);
      cycle();
      bus.dllp_valid = 0;
      check("t5_sdp", 512'(bus.Data_out[15:0]), 512'(16'hFF5C));
      cycle();
      idle_inputs();
      check("t5_stp", 512'(bus.Data_out[39:0]), 512'(40'hFD323130FB));
      cycle();

      // 6: reset in TLP_BODY, then a one-byte TLP
      set_tlp(1, 0, 64, 0, 8'h50);
      cycle();
      idle_inputs();
      reset = 1;
      cycle();
      reset = 0;
      check("t6_rst_data",  bus.Data_out,    512'h0);
      check("t6_rst_valid", 512'(bus.valid), 512'h0);
      set_tlp(1, 1, 1, 0, 8'hAB);
      cycle();
      idle_inputs();
      check("t6_word", 512'(bus.Data_out[31:0]), 512'(32'hF7FDABFB));
      cycle();

      // orphan beat in IDLE
      set_tlp(0, 1, 5, 0, 8'h01);
      cycle();
      idle_inputs();
      check("orphan_err",   512'(bus.proto_err), 512'h1);
      check("orphan_valid", 512'(bus.valid),     512'h0);
      cycle();

      // n=0 -> error, framed as 64
      set_tlp(1, 1, 0, 0, 8'h01);
      cycle();
      idle_inputs();
      check("n0_err", 512'(bus.proto_err), 512'h1);
      cycle();
      check("n0_tail", 512'(bus.Data_out[15:0]), 512'(16'hFD40));

      // sop inside body, plus an idle gap
      set_tlp(1, 0, 64, 0, 8'h05);
      cycle();
      idle_inputs();
      cycle();
      check("gap_idle", 512'(bus.valid), 512'h0);
      set_tlp(1, 1, 10, 0, 8'h70);
      cycle();
      idle_inputs();
      check("body_sop_err",   512'(bus.proto_err),     512'h1);
      check("body_sop_carry", 512'(bus.Data_out[7:0]), 512'(8'h44));
      cycle();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
